// File: rtl/blc_multi_csr.sv
// AXI4-Lite register bank for the multi-channel black level calibration core.
// Holds working copies of the mode and per-channel manual levels. These are copied
// to the datapath-facing shadows on start-of-frame. The bank also exposes a status
// register and a live read-back of the measured levels.
module blc_multi_csr #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CH_CNT    = 4,
    parameter int          BL_W      = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [31:0]            csr_awaddr_i,
    input  logic                   csr_awvalid_i,
    output logic                   csr_awready_o,
    input  logic [31:0]            csr_wdata_i,
    input  logic [3:0]             csr_wstrb_i,
    input  logic                   csr_wvalid_i,
    output logic                   csr_wready_o,
    output logic [1:0]             csr_bresp_o,
    output logic                   csr_bvalid_o,
    input  logic                   csr_bready_i,
    input  logic [31:0]            csr_araddr_i,
    input  logic                   csr_arvalid_i,
    output logic                   csr_arready_o,
    output logic [31:0]            csr_rdata_o,
    output logic [1:0]             csr_rresp_o,
    output logic                   csr_rvalid_o,
    input  logic                   csr_rready_i,
    input  logic                   sof_i,
    input  logic                   cal_busy_i,
    input  logic [CH_CNT*BL_W-1:0] cur_bl_i,
    output logic                   mode_o,
    output logic                   cal_stb_o,
    output logic [CH_CNT*BL_W-1:0] man_bl_o,
    output logic                   cfg_upd_o
);

    localparam int NUM_REGS = 4 + 2 * CH_CNT;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // write channel holding registers
    logic              aw_held_reg;
    logic [31:0]       aw_addr_reg;
    logic              w_held_reg;
    logic [31:0]       w_data_reg;
    logic [3:0]        w_strb_reg;
    logic              bvalid_reg;
    logic [1:0]        bresp_reg;

    // read channel registers
    logic              rvalid_reg;
    logic [31:0]       rdata_reg;
    logic [1:0]        rresp_reg;

    // working registers, shadows and pulses
    logic              mode_wk_reg;
    logic              mode_sh_reg;
    logic [BL_W-1:0]   bl_wk_reg [CH_CNT];
    logic [BL_W-1:0]   bl_sh_reg [CH_CNT];
    logic              upd_pending_reg;
    logic              cfg_upd_reg;
    logic              cal_req_reg;
    logic              cal_stb_reg;

    // write decode
    logic              commit;
    logic              wr_below;
    logic [31:0]       wr_idx;
    logic              wr_err;
    logic              wr_shadowed;
    logic [CH_CNT-1:0] wr_ch_sel;

    // read decode
    logic              rd_below;
    logic [31:0]       rd_idx;
    logic              rd_err;
    logic [31:0]       rd_data;
    logic [BL_W-1:0]   cur_bl_ch [CH_CNT];

    // Byte-strobe merge of new write data over an existing 32-bit value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Readies are gated by the reset input so they stay low while it is asserted.
    assign csr_awready_o = rst_i & ~aw_held_reg & ~bvalid_reg;
    assign csr_wready_o  = rst_i & ~w_held_reg & ~bvalid_reg;
    assign csr_arready_o = rst_i & ~rvalid_reg;
    assign csr_bvalid_o  = bvalid_reg;
    assign csr_bresp_o   = bresp_reg;
    assign csr_rvalid_o  = rvalid_reg;
    assign csr_rdata_o   = rdata_reg;
    assign csr_rresp_o   = rresp_reg;
    assign mode_o        = mode_sh_reg;
    assign cfg_upd_o     = cfg_upd_reg;
    assign cal_stb_o     = cal_stb_reg;

    // A write commits once both address and data are captured.
    assign commit      = aw_held_reg & w_held_reg;
    assign wr_below    = aw_addr_reg < BASE_ADDR;
    assign wr_idx      = (aw_addr_reg - BASE_ADDR) >> 2;
    // STATUS, the measured-level registers and anything past the map cannot be written.
    assign wr_err      = wr_below || (wr_idx == 32'd2) || (wr_idx >= 32'(4 + CH_CNT));
    assign wr_shadowed = !wr_err && ((wr_idx == 32'd0) || (wr_idx >= 32'd4));

    assign rd_below = csr_araddr_i < BASE_ADDR;
    assign rd_idx   = (csr_araddr_i - BASE_ADDR) >> 2;
    assign rd_err   = rd_below || (rd_idx >= 32'(NUM_REGS));

    genvar gi;
    generate
        for (gi = 0; gi < CH_CNT; gi++) begin : g_ch
            assign man_bl_o[gi*BL_W +: BL_W] = bl_sh_reg[gi];
            assign cur_bl_ch[gi]             = cur_bl_i[gi*BL_W +: BL_W];
            assign wr_ch_sel[gi]             = commit && !wr_err && (wr_idx == 32'(4 + gi));
        end
    endgenerate

    // Read data mux; errors and write-only locations return zero.
    always_comb begin
        rd_data = '0;
        if (!rd_err) begin
            if (rd_idx == 32'd0) begin
                rd_data = {31'b0, mode_wk_reg};
            end else if (rd_idx == 32'd2) begin
                rd_data = {30'b0, cal_busy_i, upd_pending_reg};
            end
            for (int c = 0; c < CH_CNT; c++) begin
                if (rd_idx == 32'(4 + c)) begin
                    rd_data = 32'(bl_wk_reg[c]);
                end
                if (rd_idx == 32'(4 + CH_CNT + c)) begin
                    rd_data = 32'(cur_bl_ch[c]);
                end
            end
        end
    end

    // Write channel: capture AW and W independently, then commit and respond.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            aw_held_reg <= 1'b0;
            aw_addr_reg <= '0;
            w_held_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            if (csr_awvalid_i && csr_awready_o) begin
                aw_held_reg <= 1'b1;
                aw_addr_reg <= csr_awaddr_i;
            end
            if (csr_wvalid_i && csr_wready_o) begin
                w_held_reg <= 1'b1;
                w_data_reg <= csr_wdata_i;
                w_strb_reg <= csr_wstrb_i;
            end
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_reg && csr_bready_i) begin
                bvalid_reg <= 1'b0;
                bresp_reg  <= RESP_OKAY;
            end
        end
    end

    // Read channel: register data at the AR handshake, clear it after the R handshake.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else if (csr_arvalid_i && csr_arready_o) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_data;
            rresp_reg  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_reg && csr_rready_i) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end
    end

    // Working registers, frame-synchronous shadow load and the calibration strobe.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mode_wk_reg     <= 1'b0;
            mode_sh_reg     <= 1'b0;
            upd_pending_reg <= 1'b0;
            cfg_upd_reg     <= 1'b0;
            cal_req_reg     <= 1'b0;
            cal_stb_reg     <= 1'b0;
            for (int c = 0; c < CH_CNT; c++) begin
                bl_wk_reg[c] <= '0;
                bl_sh_reg[c] <= '0;
            end
        end else begin
            // strobe is delayed one cycle past the commit
            cal_req_reg <= commit && !wr_err && (wr_idx == 32'd1) && w_strb_reg[0] && w_data_reg[0];
            cal_stb_reg <= cal_req_reg;

            if (commit && !wr_err && (wr_idx == 32'd0) && w_strb_reg[0]) begin
                mode_wk_reg <= w_data_reg[0];
            end
            for (int c = 0; c < CH_CNT; c++) begin
                if (wr_ch_sel[c]) begin
                    bl_wk_reg[c] <= BL_W'(merge_bytes(32'(bl_wk_reg[c]), w_data_reg, w_strb_reg));
                end
            end

            // shadows take the pre-write working values when sof meets a commit
            cfg_upd_reg <= 1'b0;
            if (sof_i && upd_pending_reg) begin
                mode_sh_reg     <= mode_wk_reg;
                cfg_upd_reg     <= 1'b1;
                upd_pending_reg <= 1'b0;
                for (int c = 0; c < CH_CNT; c++) begin
                    bl_sh_reg[c] <= bl_wk_reg[c];
                end
            end
            // a new commit keeps the update pending even if sof just consumed it
            if (commit && wr_shadowed) begin
                upd_pending_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_blc_multi_csr.sv
// Directed testbench for blc_multi_csr (CH_CNT=4, BL_W=12, non-zero base address).
module tb_blc_multi_csr;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int CH = 4;
    localparam int BW = 12;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [31:0]   awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [31:0]   araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic          sof;
    logic          cal_busy;
    logic [CH*BW-1:0] cur_bl;
    logic          mode;
    logic          cal_stb;
    logic [CH*BW-1:0] man_bl;
    logic          cfg_upd;

    int total = 0;
    int bad = 0;
    int cal_cnt = 0;
    int cfg_cnt = 0;

    always #5 clk = ~clk;

    blc_multi_csr #(.BASE_ADDR(BASE), .CH_CNT(CH), .BL_W(BW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .csr_awaddr_i(awaddr), .csr_awvalid_i(awvalid), .csr_awready_o(awready),
        .csr_wdata_i(wdata), .csr_wstrb_i(wstrb), .csr_wvalid_i(wvalid), .csr_wready_o(wready),
        .csr_bresp_o(bresp), .csr_bvalid_o(bvalid), .csr_bready_i(bready),
        .csr_araddr_i(araddr), .csr_arvalid_i(arvalid), .csr_arready_o(arready),
        .csr_rdata_o(rdata), .csr_rresp_o(rresp), .csr_rvalid_o(rvalid), .csr_rready_i(rready),
        .sof_i(sof), .cal_busy_i(cal_busy), .cur_bl_i(cur_bl),
        .mode_o(mode), .cal_stb_o(cal_stb), .man_bl_o(man_bl), .cfg_upd_o(cfg_upd)
    );

    // count high cycles of the two pulse outputs
    always @(posedge clk) begin
        if (cal_stb) cal_cnt++;
        if (cfg_upd) cfg_cnt++;
    end

    function automatic logic [31:0] A(input int idx);
        return BASE + 32'(idx * 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int n;
        logic hs_aw, hs_w;
        n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while ((awvalid || wvalid) && n < 20) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            tick(); n++;
            if (hs_aw) awvalid = 1'b0;
            if (hs_w)  wvalid  = 1'b0;
        end
        while (!bvalid && n < 20) begin
            tick(); n++;
        end
        total++;
        if (!bvalid) begin
            bad++;
            $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, bvalid);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        resp = bresp;
        tick();
        bready = 1'b0;
        $display("write addr=%h data=%h strb=%h resp=%0d", a, d, s, resp);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 20) begin
            tick(); n++;
        end
        tick();
        arvalid = 1'b0;
        while (!rvalid && n < 20) begin
            tick(); n++;
        end
        total++;
        if (!rvalid) begin
            bad++;
            $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, rvalid);
        end
        d = rdata; resp = rresp;
        tick();
        rready = 1'b0;
        $display("read  addr=%h data=%h resp=%0d", a, d, resp);
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        tick(); tick();
        total++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            bad++; $display("FAIL reset_handshake got=%b required 00000", {awready, wready, arready, bvalid, rvalid});
        end
        total++;
        if ({mode, cal_stb, cfg_upd, man_bl} !== '0) begin
            bad++; $display("FAIL reset_outputs got mode=%b stb=%b upd=%b bl=%h required 0", mode, cal_stb, cfg_upd, man_bl);
        end
        total++;
        if ({bresp, rresp, rdata} !== '0) begin
            bad++; $display("FAIL reset_resp got bresp=%0d rresp=%0d rdata=%h required 0", bresp, rresp, rdata);
        end
        rst_i = 1'b1;
        tick();
        total++;
        if ({awready, wready, arready} !== 3'b111) begin
            bad++; $display("FAIL post_reset_ready got=%b required 111", {awready, wready, arready});
        end
        $display("reset done");
    endtask

    task automatic test_man_bl_shadow();
        logic [1:0] r;
        logic [31:0] d;
        int c0;
        do_write(A(6), 32'h0000_0ABC, 4'hF, r);
        total++;
        if (r !== 2'b00) begin bad++; $display("FAIL manbl_bresp got=%0d required 0", r); end
        total++;
        if (man_bl !== 48'h0) begin bad++; $display("FAIL manbl_preload got=%h required 0", man_bl); end
        do_read(A(6), d, r);
        total++;
        if (d !== 32'h0000_0ABC || r !== 2'b00) begin bad++; $display("FAIL manbl_readback got=%h/%0d required 00000abc/0", d, r); end
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL rdata_clear got=%h required 0", rdata); end
        do_read(A(2), d, r);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL status_pending got=%h required 1", d); end
        c0 = cfg_cnt;
        pulse_sof();
        total++;
        if (man_bl !== 48'h000A_BC00_0000 || cfg_upd !== 1'b1) begin
            bad++; $display("FAIL manbl_sof got bl=%h upd=%b required 000abc000000/1", man_bl, cfg_upd);
        end
        tick(); tick();
        pulse_sof();
        tick();
        total++;
        if (cfg_cnt - c0 !== 1) begin bad++; $display("FAIL cfg_upd_count got=%0d required 1", cfg_cnt - c0); end
        do_read(A(2), d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL status_cleared got=%h required 0", d); end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0] r;
        wdata = 32'h0000_0123; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        tick();
        wvalid = 1'b0;
        total++;
        if (wready !== 1'b0 || awready !== 1'b1) begin
            bad++; $display("FAIL w_held_ready got w=%b aw=%b required 0/1", wready, awready);
        end
        tick(); tick();
        awaddr = A(4); awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        total++;
        if (bvalid !== 1'b0 || awready !== 1'b0) begin
            bad++; $display("FAIL aw_accept got bvalid=%b awready=%b required 0/0", bvalid, awready);
        end
        tick();
        total++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            bad++; $display("FAIL commit_latency got bvalid=%b bresp=%0d required 1/0", bvalid, bresp);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
                bad++; $display("FAIL bvalid_hold cyc=%0d got b=%b aw=%b w=%b required 1/0/0", i, bvalid, awready, wready);
            end
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        total++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            bad++; $display("FAIL b_release got b=%b aw=%b w=%b required 0/1/1", bvalid, awready, wready);
        end
        do_read(A(4), d, r);
        total++;
        if (d !== 32'h123) begin bad++; $display("FAIL w_first_data got=%h required 123", d); end
    endtask

    task automatic test_cal_stb();
        logic [1:0] r;
        logic [31:0] d;
        int c0;
        c0 = cal_cnt;
        do_write(A(1), 32'h1, 4'hF, r);
        total++;
        if (cal_stb !== 1'b1) begin bad++; $display("FAIL cal_stb_timing got=%b required 1", cal_stb); end
        do_write(A(1), 32'h1, 4'hF, r);
        tick(); tick(); tick();
        total++;
        if (cal_cnt - c0 !== 2) begin bad++; $display("FAIL cal_stb_count got=%0d required 2", cal_cnt - c0); end
        do_write(A(1), 32'h0, 4'hF, r);
        tick(); tick();
        total++;
        if (cal_cnt - c0 !== 2) begin bad++; $display("FAIL cal_stb_zero got=%0d required 2", cal_cnt - c0); end
        do_read(A(1), d, r);
        total++;
        if (d !== 32'h0 || r !== 2'b00) begin bad++; $display("FAIL cal_read got=%h/%0d required 0/0", d, r); end
    endtask

    task automatic test_errors();
        logic [1:0] r;
        logic [31:0] d;
        pulse_sof();
        do_write(A(3), 32'hFFFF_FFFF, 4'hF, r);
        total++;
        if (r !== 2'b00) begin bad++; $display("FAIL reserved_write got=%0d required 0", r); end
        do_read(A(3), d, r);
        total++;
        if (d !== 32'h0 || r !== 2'b00) begin bad++; $display("FAIL reserved_read got=%h/%0d required 0/0", d, r); end
        do_write(A(2), 32'h3, 4'hF, r);
        total++;
        if (r !== 2'b10) begin bad++; $display("FAIL status_write got=%0d required 2", r); end
        do_write(A(8), 32'h7, 4'hF, r);
        total++;
        if (r !== 2'b10) begin bad++; $display("FAIL cur_write got=%0d required 2", r); end
        do_write(A(12), 32'h7, 4'hF, r);
        total++;
        if (r !== 2'b10) begin bad++; $display("FAIL oob_write got=%0d required 2", r); end
        do_write(BASE - 32'd4, 32'h1, 4'hF, r);
        total++;
        if (r !== 2'b10) begin bad++; $display("FAIL below_write got=%0d required 2", r); end
        do_read(A(2), d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL err_no_pending got=%h required 0", d); end
        do_read(A(12), d, r);
        total++;
        if (d !== 32'h0 || r !== 2'b10) begin bad++; $display("FAIL oob_read got=%h/%0d required 0/2", d, r); end
        do_read(BASE - 32'd4, d, r);
        total++;
        if (d !== 32'h0 || r !== 2'b10) begin bad++; $display("FAIL below_read got=%h/%0d required 0/2", d, r); end
        do_read(A(0), d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL below_no_effect got=%h required 0", d); end
        do_write(A(5), 32'hFFFF_FFFF, 4'hF, r);
        do_read(A(5), d, r);
        total++;
        if (d !== 32'hFFF) begin bad++; $display("FAIL upper_ignored got=%h required fff", d); end
        do_write(A(5), 32'h0000_00AB, 4'h1, r);
        do_read(A(5), d, r);
        total++;
        if (d !== 32'hFAB) begin bad++; $display("FAIL strb_byte0 got=%h required fab", d); end
        do_write(A(5), 32'h0000_0500, 4'h2, r);
        do_read(A(5), d, r);
        total++;
        if (d !== 32'h5AB) begin bad++; $display("FAIL strb_byte1 got=%h required 5ab", d); end
        cur_bl = {12'h444, 12'h333, 12'h222, 12'h111};
        cal_busy = 1'b1;
        do_read(A(9), d, r);
        total++;
        if (d !== 32'h222 || r !== 2'b00) begin bad++; $display("FAIL cur_read got=%h/%0d required 222/0", d, r); end
        do_read(A(2), d, r);
        total++;
        if (d !== 32'h3) begin bad++; $display("FAIL status_busy got=%h required 3", d); end
        cal_busy = 1'b0;
    endtask

    task automatic test_mode();
        logic [1:0] r;
        logic [31:0] d;
        do_write(A(0), 32'h1, 4'hF, r);
        do_read(A(0), d, r);
        total++;
        if (d !== 32'h1 || mode !== 1'b0) begin bad++; $display("FAIL mode_pre got reg=%h out=%b required 1/0", d, mode); end
        pulse_sof();
        total++;
        if (mode !== 1'b1) begin bad++; $display("FAIL mode_sof got=%b required 1", mode); end
    endtask

    task automatic test_sof_coincide();
        logic [1:0] r;
        logic [31:0] d;
        do_write(A(4), 32'h456, 4'hF, r);
        awaddr = A(4); wdata = 32'h789; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        sof = 1'b1; araddr = A(4); arvalid = 1'b1; rready = 1'b0;
        tick();
        sof = 1'b0; arvalid = 1'b0;
        total++;
        if (bvalid !== 1'b1 || cfg_upd !== 1'b1 || man_bl[BW-1:0] !== 12'h456) begin
            bad++; $display("FAIL coincide_shadow got b=%b upd=%b ch0=%h required 1/1/456", bvalid, cfg_upd, man_bl[BW-1:0]);
        end
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'h456) begin
            bad++; $display("FAIL coincide_read got v=%b d=%h required 1/456", rvalid, rdata);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        $display("coincide write addr=%h data=789 with sof and read", A(4));
        do_read(A(2), d, r);
        total++;
        if (d[0] !== 1'b1) begin bad++; $display("FAIL coincide_pending got=%h required bit0 1", d); end
        pulse_sof();
        total++;
        if (man_bl[BW-1:0] !== 12'h789) begin bad++; $display("FAIL coincide_next got=%h required 789", man_bl[BW-1:0]); end
    endtask

    task automatic test_reset_mid_write();
        logic [1:0] r;
        logic [31:0] d;
        awaddr = A(5); awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wdata = 32'hEEE; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        rst_i = 1'b0;
        tick();
        total++;
        if ({bvalid, awready, wready, arready} !== 4'b0) begin
            bad++; $display("FAIL midrst_hs got=%b required 0000", {bvalid, awready, wready, arready});
        end
        total++;
        if ({mode, man_bl, cfg_upd, cal_stb} !== '0) begin
            bad++; $display("FAIL midrst_out got mode=%b bl=%h required 0", mode, man_bl);
        end
        wvalid = 1'b0; bready = 1'b0; rst_i = 1'b1;
        tick(); tick();
        total++;
        if (bvalid !== 1'b0 || {awready, wready, arready} !== 3'b111) begin
            bad++; $display("FAIL midrst_after got b=%b rdy=%b required 0/111", bvalid, {awready, wready, arready});
        end
        do_read(A(4), d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL midrst_regs got=%h required 0", d); end
        do_write(A(5), 32'h321, 4'hF, r);
        total++;
        if (r !== 2'b00) begin bad++; $display("FAIL midrst_write got=%0d required 0", r); end
        do_read(A(5), d, r);
        total++;
        if (d !== 32'h321) begin bad++; $display("FAIL midrst_read got=%h required 321", d); end
    endtask

    initial begin
        rst_i = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        sof = 1'b0; cal_busy = 1'b0; cur_bl = '0;
        test_reset();
        test_man_bl_shadow();
        test_w_before_aw();
        test_cal_stb();
        test_errors();
        test_mode();
        test_sof_coincide();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
